// File: rtl/render_pkg.sv
// Shared types and default render-window constants for the frame scheduler
// and the frame-buffer address math in top_level.
package render_pkg;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    localparam int DEF_START_X = 260;
    localparam int DEF_START_Y = 195;
    localparam int DEF_END_X   = 390;
    localparam int DEF_END_Y   = 295;

    localparam int DEF_MAX_INFLIGHT = 512;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        READY
    } state_t;

endpackage

// File: rtl/credit_counter.sv
// In-flight coordinate counter: handshakes add a credit, renderer
// completions return one; a completion with nothing outstanding is sticky.
module credit_counter #(
    parameter int MAX_INFLIGHT = 512,
    localparam int CW = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_err
);

    logic [CW-1:0] r_count;
    logic          r_err;
    logic [CW-1:0] w_next;
    logic          w_underflow;

    always_comb begin
        w_underflow = i_dec && !i_inc && (r_count == '0);
        w_next      = r_count;
        if (i_inc && !i_dec) begin
            w_next = r_count + 1'b1;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            w_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_next;
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    // Full reflects the count after this cycle's update so tvalid can be
    // registered one cycle ahead without ever overshooting the limit.
    assign o_full  = (w_next >= CW'(MAX_INFLIGHT));
    assign o_count = r_count;
    assign o_err   = r_err;

endmodule

// File: rtl/render_frame_scheduler.sv
// Walks the render window once per display frame, issuing credit-limited
// coordinates over AXI-Stream and swapping frame banks at nf boundaries.
module render_frame_scheduler
    import render_pkg::*;
#(
    parameter int START_X      = DEF_START_X,
    parameter int START_Y      = DEF_START_Y,
    parameter int END_X        = DEF_END_X,
    parameter int END_Y        = DEF_END_Y,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                nf_in,
    output logic [HCOUNT_W-1:0] hcount_axis_tdata,
    output logic [VCOUNT_W-1:0] vcount_axis_tdata,
    output logic                coord_axis_tvalid,
    input  logic                coord_axis_tready,
    input  logic                pixel_valid_in,
    output logic                wr_bank_out,
    output logic                rd_bank_out,
    output logic                busy_out,
    output logic                frame_done_out,
    output logic [15:0]         overrun_count_out,
    output logic                credit_err_out
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    localparam logic [HCOUNT_W-1:0] SX = HCOUNT_W'(START_X);
    localparam logic [HCOUNT_W-1:0] LX = HCOUNT_W'(END_X - 1);
    localparam logic [VCOUNT_W-1:0] SY = VCOUNT_W'(START_Y);
    localparam logic [VCOUNT_W-1:0] LY = VCOUNT_W'(END_Y - 1);

    state_t              r_state;
    logic [HCOUNT_W-1:0] r_x;
    logic [VCOUNT_W-1:0] r_y;
    logic                r_tvalid;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic                r_busy;
    logic                r_done;
    logic [15:0]         r_overrun;

    logic                w_hs;
    logic                w_last;
    logic                w_full;
    logic                w_err;
    logic [CW-1:0]       w_count;

    assign w_hs   = r_tvalid && coord_axis_tready;
    assign w_last = (r_x == LX) && (r_y == LY);

    credit_counter #(
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_credit (
        .i_clk   (aclk),
        .i_rst_n (aresetn),
        .i_inc   (w_hs),
        .i_dec   (pixel_valid_in),
        .o_count (w_count),
        .o_full  (w_full),
        .o_err   (w_err)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_x       <= SX;
            r_y       <= SY;
            r_tvalid  <= 1'b0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= '0;
        end else begin
            r_done <= 1'b0;
            if (nf_in && r_busy && (r_overrun != 16'hFFFF)) begin
                r_overrun <= r_overrun + 1'b1;
            end
            unique case (r_state)
                IDLE, READY: begin
                    if (nf_in) begin
                        r_state  <= ISSUE;
                        r_busy   <= 1'b1;
                        r_x      <= SX;
                        r_y      <= SY;
                        r_tvalid <= !w_full;
                        if (r_state == READY) begin
                            r_wr_bank <= r_rd_bank;
                            r_rd_bank <= r_wr_bank;
                        end
                    end
                end
                ISSUE: begin
                    r_tvalid <= !w_full;
                    if (w_hs) begin
                        if (w_last) begin
                            r_state  <= DRAIN;
                            r_tvalid <= 1'b0;
                            r_x      <= SX;
                            r_y      <= SY;
                        end else if (r_x == LX) begin
                            r_x <= SX;
                            r_y <= r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Done only once the last completion has actually landed.
                    if ((w_count == '0) && !pixel_valid_in) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign hcount_axis_tdata = r_x;
    assign vcount_axis_tdata = r_y;
    assign coord_axis_tvalid = r_tvalid;
    assign wr_bank_out       = r_wr_bank;
    assign rd_bank_out       = r_rd_bank;
    assign busy_out          = r_busy;
    assign frame_done_out    = r_done;
    assign overrun_count_out = r_overrun;
    assign credit_err_out    = w_err;

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Scoreboard bench: full-size window instance plus a tiny window instance
// with a 4-deep credit limit for stall, hold and credit-arithmetic cases.
module tb_render_frame_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // ---------------- instance A: default window ----------------
    logic        rstn_a, nf_a, rdy_a, pvf_a;
    logic        pv_a;
    logic [10:0] h_a;
    logic [9:0]  v_a;
    logic        tv_a, wr_a, rd_a, busy_a, done_a, err_a;
    logic [15:0] ovr_a;
    logic [3:0]  pipe_a = '0;
    logic [20:0] q_a[$];
    logic [20:0] e_a;
    int          done_cnt_a = 0;

    assign pv_a = pipe_a[3] | pvf_a;

    render_frame_scheduler u_dut_a (
        .aclk              (clk),
        .aresetn           (rstn_a),
        .nf_in             (nf_a),
        .hcount_axis_tdata (h_a),
        .vcount_axis_tdata (v_a),
        .coord_axis_tvalid (tv_a),
        .coord_axis_tready (rdy_a),
        .pixel_valid_in    (pv_a),
        .wr_bank_out       (wr_a),
        .rd_bank_out       (rd_a),
        .busy_out          (busy_a),
        .frame_done_out    (done_a),
        .overrun_count_out (ovr_a),
        .credit_err_out    (err_a)
    );

    always @(negedge clk) begin
        if (rstn_a && tv_a && rdy_a) begin
            if (q_a.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_extra: got (%0d,%0d) required none", h_a, v_a);
            end else begin
                e_a = q_a.pop_front();
                check("a_coord", {11'd0, h_a, v_a}, {11'd0, e_a});
            end
        end
        if (rstn_a && done_a) done_cnt_a++;
        pipe_a = rstn_a ? {pipe_a[2:0], tv_a & rdy_a} : 4'd0;
    end

    // ---------------- instance B: 3x3 window, 4 credits ----------------
    logic        rstn_b, nf_b, rdy_b, pvf_b, auto_b;
    logic        pv_b;
    logic [10:0] h_b;
    logic [9:0]  v_b;
    logic        tv_b, wr_b, rd_b, busy_b, done_b, err_b;
    logic [15:0] ovr_b;
    logic [3:0]  pipe_b = '0;
    logic [20:0] q_b[$];
    logic [20:0] e_b;
    logic [20:0] prev_d_b = '0;
    logic        prev_tv_b = 1'b0;
    logic        prev_rdy_b = 1'b0;
    int          done_cnt_b = 0;
    int          hs_cnt_b = 0;

    assign pv_b = pipe_b[3] | pvf_b;

    render_frame_scheduler #(
        .START_X      (10),
        .START_Y      (5),
        .END_X        (13),
        .END_Y        (8),
        .MAX_INFLIGHT (4)
    ) u_dut_b (
        .aclk              (clk),
        .aresetn           (rstn_b),
        .nf_in             (nf_b),
        .hcount_axis_tdata (h_b),
        .vcount_axis_tdata (v_b),
        .coord_axis_tvalid (tv_b),
        .coord_axis_tready (rdy_b),
        .pixel_valid_in    (pv_b),
        .wr_bank_out       (wr_b),
        .rd_bank_out       (rd_b),
        .busy_out          (busy_b),
        .frame_done_out    (done_b),
        .overrun_count_out (ovr_b),
        .credit_err_out    (err_b)
    );

    always @(negedge clk) begin
        if (rstn_b && prev_tv_b && !prev_rdy_b) begin
            check("b_hold_valid", {31'd0, tv_b}, 32'd1);
            check("b_hold_data", {11'd0, h_b, v_b}, {11'd0, prev_d_b});
        end
        if (rstn_b && tv_b && rdy_b) begin
            hs_cnt_b++;
            if (q_b.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_extra: got (%0d,%0d) required none", h_b, v_b);
            end else begin
                e_b = q_b.pop_front();
                check("b_coord", {11'd0, h_b, v_b}, {11'd0, e_b});
            end
        end
        if (rstn_b && done_b) done_cnt_b++;
        prev_tv_b  = rstn_b && tv_b;
        prev_rdy_b = rdy_b;
        prev_d_b   = {h_b, v_b};
        pipe_b = rstn_b ? {pipe_b[2:0], tv_b & rdy_b & auto_b} : 4'd0;
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_frame_a();
        for (int y = 195; y < 295; y++)
            for (int x = 260; x < 390; x++)
                q_a.push_back({11'(x), 10'(y)});
    endtask

    task automatic push_frame_b();
        for (int y = 5; y < 8; y++)
            for (int x = 10; x < 13; x++)
                q_b.push_back({11'(x), 10'(y)});
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_nf_a();
        nf_a = 1'b1;
        step(1);
        nf_a = 1'b0;
    endtask

    task automatic pulse_nf_b();
        nf_b = 1'b1;
        step(1);
        nf_b = 1'b0;
    endtask

    task automatic wait_done_a(int target, int limit);
        int k = 0;
        while (done_cnt_a < target && k < limit) begin
            step(1);
            k++;
        end
        check("a_frame_done", 32'(done_cnt_a), 32'(target));
    endtask

    task automatic run_b(int target, int limit);
        logic [31:0] pat = 32'hB53C_96E1;
        int k = 0;
        while (done_cnt_b < target && k < limit) begin
            rdy_b = pat[k % 32];
            step(1);
            k++;
        end
        rdy_b = 1'b0;
        check("b_frame_done", 32'(done_cnt_b), 32'(target));
    endtask

    // ---------------- sequence A ----------------
    task automatic seq_a();
        rstn_a = 1'b0; nf_a = 1'b0; rdy_a = 1'b1; pvf_a = 1'b0;
        step(1);
        check("a_rst_tvalid", {31'd0, tv_a}, 32'd0);
        check("a_rst_wr", {31'd0, wr_a}, 32'd0);
        check("a_rst_rd", {31'd0, rd_a}, 32'd1);
        check("a_rst_busy", {31'd0, busy_a}, 32'd0);
        check("a_rst_h", {21'd0, h_a}, 32'd260);
        check("a_rst_v", {22'd0, v_a}, 32'd195);
        rstn_a = 1'b1;
        step(2);
        check("a_idle_tvalid", {31'd0, tv_a}, 32'd0);

        push_frame_a();
        pulse_nf_a();
        check("a_start_tvalid", {31'd0, tv_a}, 32'd1);
        check("a_start_busy", {31'd0, busy_a}, 32'd1);
        check("a_start_h", {21'd0, h_a}, 32'd260);
        check("a_start_v", {22'd0, v_a}, 32'd195);

        repeat (3) begin
            step(100);
            pulse_nf_a();
        end
        step(1);
        check("a_overrun3", {16'd0, ovr_a}, 32'd3);
        check("a_busy_noswap", {31'd0, wr_a}, 32'd0);

        wait_done_a(1, 20000);
        step(4);
        check("a_done_once", 32'(done_cnt_a), 32'd1);
        check("a_q_empty", 32'(q_a.size()), 32'd0);
        check("a_ready_wr", {31'd0, wr_a}, 32'd0);
        check("a_ready_rd", {31'd0, rd_a}, 32'd1);
        check("a_ready_busy", {31'd0, busy_a}, 32'd0);
        check("a_err_clean", {31'd0, err_a}, 32'd0);

        pvf_a = 1'b1;
        step(1);
        pvf_a = 1'b0;
        check("a_err_set", {31'd0, err_a}, 32'd1);
        step(5);
        check("a_err_sticky", {31'd0, err_a}, 32'd1);

        push_frame_a();
        pulse_nf_a();
        check("a_swap_wr", {31'd0, wr_a}, 32'd1);
        check("a_swap_rd", {31'd0, rd_a}, 32'd0);
        check("a_ovr_ready", {16'd0, ovr_a}, 32'd3);
        check("a_f2_h", {21'd0, h_a}, 32'd260);

        step(500);
        rdy_a = 1'b0;
        rstn_a = 1'b0;
        step(1);
        rstn_a = 1'b1;
        q_a.delete();
        check("a_mid_rst_tvalid", {31'd0, tv_a}, 32'd0);
        check("a_mid_rst_wr", {31'd0, wr_a}, 32'd0);
        check("a_mid_rst_rd", {31'd0, rd_a}, 32'd1);
        check("a_mid_rst_busy", {31'd0, busy_a}, 32'd0);
        check("a_mid_rst_ovr", {16'd0, ovr_a}, 32'd0);
        check("a_mid_rst_err", {31'd0, err_a}, 32'd0);
        step(8);
        check("a_post_rst_err", {31'd0, err_a}, 32'd0);
        pulse_nf_a();
        check("a_restart_tvalid", {31'd0, tv_a}, 32'd1);
        check("a_restart_h", {21'd0, h_a}, 32'd260);
        check("a_restart_v", {22'd0, v_a}, 32'd195);
    endtask

    // ---------------- sequence B ----------------
    task automatic seq_b();
        rstn_b = 1'b0; nf_b = 1'b0; rdy_b = 1'b1; pvf_b = 1'b0; auto_b = 1'b0;
        step(1);
        check("b_rst_tvalid", {31'd0, tv_b}, 32'd0);
        rstn_b = 1'b1;
        step(1);

        push_frame_b();
        pulse_nf_b();
        step(10);
        check("b_credit_hs", 32'(hs_cnt_b), 32'd4);
        check("b_credit_stall", {31'd0, tv_b}, 32'd0);

        pvf_b = 1'b1;
        step(1);
        pvf_b = 1'b0;
        check("b_credit_return", {31'd0, tv_b}, 32'd1);
        step(5);
        check("b_one_more_hs", 32'(hs_cnt_b), 32'd5);
        check("b_restall", {31'd0, tv_b}, 32'd0);

        rdy_b = 1'b0;
        pvf_b = 1'b1;
        step(2);
        pvf_b = 1'b0;
        check("b_inflight2_valid", {31'd0, tv_b}, 32'd1);
        rdy_b = 1'b1;
        pvf_b = 1'b1;
        step(1);
        rdy_b = 1'b0;
        pvf_b = 1'b0;
        rdy_b = 1'b1;
        step(6);
        check("b_simul_hs", 32'(hs_cnt_b), 32'd8);
        check("b_simul_stall", {31'd0, tv_b}, 32'd0);

        rdy_b = 1'b0;
        pvf_b = 1'b1;
        step(4);
        pvf_b = 1'b0;
        check("b_err_clean", {31'd0, err_b}, 32'd0);
        auto_b = 1'b1;
        run_b(1, 300);
        check("b_f1_wr", {31'd0, wr_b}, 32'd0);

        push_frame_b();
        pulse_nf_b();
        check("b_swap_wr", {31'd0, wr_b}, 32'd1);
        check("b_swap_rd", {31'd0, rd_b}, 32'd0);
        run_b(2, 300);
        step(3);
        check("b_total_hs", 32'(hs_cnt_b), 32'd18);
        check("b_q_empty", 32'(q_b.size()), 32'd0);
        check("b_end_busy", {31'd0, busy_b}, 32'd0);
        check("b_end_err", {31'd0, err_b}, 32'd0);
        check("b_end_wr", {31'd0, wr_b}, 32'd1);
    endtask

    initial begin
        fork
            seq_a();
            seq_b();
        join
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
